// File: rtl/pwm_compare_channel_if.sv
// Signal bundle between the PWM counter/register file and one compare channel.
// The master side drives the counter and configuration; the slave side is the channel.
interface pwm_compare_channel_if #(
  parameter int CNT_WIDTH = 16,
  parameter int DT_WIDTH  = 8
);
  logic                 cnt_en_i;
  logic [CNT_WIDTH-1:0] cnt_i;
  logic                 overflow_i;
  logic [CNT_WIDTH-1:0] ccr_preload_i;
  logic                 preload_en_i;
  logic [1:0]           mode_i;
  logic                 pol_i;
  logic [DT_WIDTH-1:0]  dtg_i;
  logic                 oc_o;
  logic                 ocn_o;
  logic                 match_o;

  modport master (
    output cnt_en_i, cnt_i, overflow_i, ccr_preload_i, preload_en_i, mode_i, pol_i, dtg_i,
    input  oc_o, ocn_o, match_o
  );

  modport slave (
    input  cnt_en_i, cnt_i, overflow_i, ccr_preload_i, preload_en_i, mode_i, pol_i, dtg_i,
    output oc_o, ocn_o, match_o
  );
endinterface

// File: rtl/pwm_compare_channel.sv
// Capture/compare output stage behind the PWM main counter: shadowed CCR, match pulse,
// reference waveform and polarity-controlled outputs. Define PWM_DEADTIME_EN for dead time.
module pwm_compare_channel #(
  parameter int CNT_WIDTH = 16,
  parameter int DT_WIDTH  = 8
) (
  input  logic                  clk_psc_i,
  input  logic                  rst_n_i,
  pwm_compare_channel_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONES    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = {CNT_WIDTH{1'b0}};
  localparam logic [1:0]           MODE_FROZEN = 2'b00;
  localparam logic [1:0]           MODE_PWM1   = 2'b01;
  localparam logic [1:0]           MODE_PWM2   = 2'b10;
  localparam logic [1:0]           MODE_TOGGLE = 2'b11;

  logic [CNT_WIDTH-1:0] r_ccr_shadow;
  logic [CNT_WIDTH-1:0] r_cnt_q;
  logic                 r_oc_ref;
  logic                 r_match;
  logic                 r_oc;
  logic                 r_ocn;
  logic                 w_load;
  logic                 w_evt;
  logic                 w_ref_next;
  logic                 w_oc_act;
  logic                 w_ocn_act;

  // Shadow update: with preload, only at overflow or while the counter is stopped
  always_comb begin
    w_load = 1'b1;
    if (bus.preload_en_i) begin
      w_load = bus.overflow_i | ~bus.cnt_en_i;
    end else begin
      w_load = 1'b1;
    end
  end

  // A held count matches once; overflow re-arms it so ARR=0 still fires every period
  assign w_evt = bus.cnt_en_i & (bus.cnt_i == r_ccr_shadow)
               & ((bus.cnt_i != r_cnt_q) | bus.overflow_i);

  // Next reference level per compare mode
  always_comb begin
    w_ref_next = r_oc_ref;
    if (!bus.cnt_en_i) begin
      w_ref_next = 1'b0;
    end else begin
      case (bus.mode_i)
        MODE_PWM1:   w_ref_next = (bus.cnt_i < r_ccr_shadow);
        MODE_PWM2:   w_ref_next = (bus.cnt_i >= r_ccr_shadow);
        MODE_TOGGLE: w_ref_next = r_oc_ref ^ w_evt;
        MODE_FROZEN: w_ref_next = r_oc_ref;
        default:     w_ref_next = r_oc_ref;
      endcase
    end
  end

  // Compare stage state
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ccr_shadow <= CNT_ZERO;
      r_cnt_q      <= CNT_ONES;
      r_oc_ref     <= 1'b0;
      r_match      <= 1'b0;
    end else begin
      if (w_load) begin
        r_ccr_shadow <= bus.ccr_preload_i;
      end
      r_cnt_q  <= bus.cnt_en_i ? bus.cnt_i : CNT_ONES;
      r_oc_ref <= w_ref_next;
      r_match  <= w_evt;
    end
  end

`ifdef PWM_DEADTIME_EN
  logic [DT_WIDTH-1:0] r_dt_cnt;
  logic [DT_WIDTH-1:0] w_dt_next;
  logic                r_ref_d;
  logic                w_ref_edge;

  assign w_ref_edge = r_oc_ref ^ r_ref_d;

  // Dead-time down-counter; any reference edge restarts it
  always_comb begin
    w_dt_next = r_dt_cnt;
    if (!bus.cnt_en_i) begin
      w_dt_next = {DT_WIDTH{1'b0}};
    end else if (w_ref_edge) begin
      w_dt_next = bus.dtg_i;
    end else if (r_dt_cnt != {DT_WIDTH{1'b0}}) begin
      w_dt_next = r_dt_cnt - {{(DT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_dt_next = r_dt_cnt;
    end
  end

  // Dead-time state
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_dt_cnt <= {DT_WIDTH{1'b0}};
      r_ref_d  <= 1'b0;
    end else begin
      r_dt_cnt <= w_dt_next;
      r_ref_d  <= r_oc_ref;
    end
  end

  // Each side may go active only once the delay following the latest edge has expired
  assign w_oc_act  =  r_oc_ref & (w_dt_next == {DT_WIDTH{1'b0}});
  assign w_ocn_act = ~r_oc_ref & (w_dt_next == {DT_WIDTH{1'b0}});
`else
  logic [DT_WIDTH-1:0] w_dtg_unused;

  assign w_dtg_unused = bus.dtg_i;
  assign w_oc_act     =  r_oc_ref;
  assign w_ocn_act    = ~r_oc_ref;
`endif

  // Output stage: inactive level while stopped, otherwise active level XOR polarity
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_oc  <= 1'b0;
      r_ocn <= 1'b0;
    end else if (!bus.cnt_en_i) begin
      r_oc  <= bus.pol_i;
      r_ocn <= bus.pol_i;
    end else begin
      r_oc  <= w_oc_act ^ bus.pol_i;
      r_ocn <= w_ocn_act ^ bus.pol_i;
    end
  end

  assign bus.oc_o    = r_oc;
  assign bus.ocn_o   = r_ocn;
  assign bus.match_o = r_match;

endmodule
